// File: rtl/sram_req_ctrl_pkg.sv
// Shared types and defaults for the SRAM request sequencer.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W = 2;
  localparam int SRAM_DATA_W = 4;
  localparam int STAT_W      = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_ISSUE = 3'd2,
    RD_CAP   = 3'd3,
    RESP     = 3'd4
  } ctrl_state_e;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sram_req_ctrl_if.sv
// Request/response channels plus the SRAM pin bus of the request sequencer.
interface sram_req_ctrl_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              wr_done;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Environment side: requester, response consumer and the SRAM itself.
  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, wr_done, rsp_valid, rsp_data,
    input  mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, wr_done, rsp_valid, rsp_data,
    output mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sram_req_ctrl.sv
// Sequences single read/write requests onto the 4x4 SRAM pins and returns read data.
// Optional SRAM_REQ_CTRL_STATS_EN adds saturating rd_cnt/wr_cnt outputs.
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  sram_req_ctrl_if.slave      bus
`ifdef SRAM_REQ_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0]   rd_cnt,
  output logic [STAT_W-1:0]   wr_cnt
`endif
);

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              accept;

  assign accept = (state_q == IDLE) && bus.req_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Request fields are only consumed in states whose outputs are gated, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  rsp_data_q <= '0;
    else if (state_q == RD_CAP) rsp_data_q <= bus.mem_rdata;
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.wr_done   = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = bus.req_wr ? WRITE : RD_ISSUE;
      end
      WRITE: begin
        bus.mem_en    = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.wr_done   = 1'b1;
        state_d       = IDLE;
      end
      RD_ISSUE: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = addr_q;
        state_d      = RD_CAP;
      end
      // Enable stays high so the store keeps driving data_out while it is captured.
      RD_CAP: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = addr_q;
        state_d      = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rsp_data = rsp_data_q;

`ifdef SRAM_REQ_CTRL_STATS_EN
  logic [STAT_W-1:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (state_q == WRITE)                  wr_cnt_q <= sat_inc(wr_cnt_q);
      if (state_q == RESP && bus.rsp_ready)  rd_cnt_q <= sat_inc(rd_cnt_q);
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: SRAM model, reference memory and read-response scoreboard.
module tb_sram_req_ctrl;
  import sram_ctrl_pkg::*;

  localparam int AW = 2;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_req_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

`ifdef SRAM_REQ_CTRL_STATS_EN
  logic [STAT_W-1:0] rd_cnt, wr_cnt;
`endif

  sram_req_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SRAM_REQ_CTRL_STATS_EN
    ,
    .rd_cnt (rd_cnt),
    .wr_cnt (wr_cnt)
`endif
  );

  // SRAM model: commit on en&wr, load read register on en&!wr, drive it while en&!wr.
  logic [DW-1:0] sram [4];
  logic [DW-1:0] sram_rreg;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_wr) sram[bus.mem_addr] <= bus.mem_wdata;
      else            sram_rreg <= sram[bus.mem_addr];
    end
  end
  // 4'hF stands in for the floating bus so a mistimed capture is visible.
  assign bus.mem_rdata = (bus.mem_en && !bus.mem_wr) ? sram_rreg : 4'hF;

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] ref_mem [4];
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && bus.rsp_valid && bus.rsp_ready) begin
      chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("rsp_data", 32'(bus.rsp_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic wait_ready();
    for (int n = 0; n < 50 && !bus.req_ready; n++) @(negedge clk);
    chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    wait_ready();
    @(posedge clk);
    ref_mem[a] = d;
    #1;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    @(negedge clk);
    chk("wr_done", 32'(bus.wr_done), 32'd1);
    chk("wr_en_wr", 32'({bus.mem_en, bus.mem_wr}), 32'd3);
    chk("wr_addr", 32'(bus.mem_addr), 32'(a));
    chk("wr_wdata", 32'(bus.mem_wdata), 32'(d));
    chk("wr_busy", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("wr_done_fall", 32'(bus.wr_done), 32'd0);
    chk("wr_idle", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int hold);
    logic [DW-1:0] d0;
    bus.rsp_ready = (hold == 0);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = a;
    wait_ready();
    @(posedge clk);
    exp_q.push_back(ref_mem[a]);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rd_issue_en", 32'({bus.mem_en, bus.mem_wr}), 32'd2);
    chk("rd_issue_addr", 32'(bus.mem_addr), 32'(a));
    chk("rd_issue_vld", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("rd_cap_en", 32'({bus.mem_en, bus.mem_wr}), 32'd2);
    chk("rd_cap_vld", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("rd_latency", 32'(bus.rsp_valid), 32'd1);
    d0 = bus.rsp_data;
    for (int i = 0; i < hold; i++) begin
      chk("hold_vld", 32'(bus.rsp_valid), 32'd1);
      chk("hold_data", 32'(bus.rsp_data), 32'(d0));
      chk("hold_busy", 32'(bus.req_ready), 32'd0);
      chk("hold_mem_en", 32'(bus.mem_en), 32'd0);
      if (i < hold - 1) @(negedge clk);
    end
    if (hold > 0) begin
      @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    chk("rsp_vld_fall", 32'(bus.rsp_valid), 32'd0);
    chk("rsp_idle", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_wr_done"}, 32'(bus.wr_done), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
    chk({tag, "_mem_ctl"}, 32'({bus.mem_en, bus.mem_wr}), 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
    sram_rreg     = '0;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    do_write(2'd2, 4'hA);
    do_write(2'd1, 4'h5);
    do_read(2'd1, 0);

    do_write(2'd0, 4'h3);
    do_write(2'd1, 4'hC);
    do_write(2'd2, 4'h6);
    do_write(2'd3, 4'h9);
    for (int i = 3; i >= 0; i--) do_read(2'(i), 0);

    do_read(2'd2, 5);

    // Reset in RD_CAP: rsp_data still holds 0x6 from the previous read.
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 2'd2;
    wait_ready();
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_cap", 32'({bus.mem_en, bus.mem_wr}), 32'd2);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_read(2'd3, 0);

    do_write(2'd0, 4'hB);
    do_read(2'd0, 0);

`ifdef SRAM_REQ_CTRL_STATS_EN
    rst = 1'b0;
    @(negedge clk);
    chk("stats_rst_wr", 32'(wr_cnt), 32'd0);
    chk("stats_rst_rd", 32'(rd_cnt), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 300; i++) do_write(2'(i), 4'(i));
    do_read(2'd1, 0);
    do_read(2'd2, 3);
    chk("stats_wr_cnt", 32'(wr_cnt), 32'd255);
    chk("stats_rd_cnt", 32'(rd_cnt), 32'd2);
`endif

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
